// File: rtl/maze_pkg.sv
// Shared types and constants for the MazeRunner command sequencer.
package maze_pkg;

   typedef enum logic [2:0] {
      OP_CAL   = 3'd0,
      OP_HDG   = 3'd1,
      OP_MOVE  = 3'd2,
      OP_SOLVE = 3'd3
   } opcode_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAL     = 3'd1,
      HDG     = 3'd2,
      MOVE    = 3'd3,
      SOLVE   = 3'd4,
      RESP    = 3'd5,
      WAIT_TX = 3'd6
   } seq_state_t;

   localparam logic [7:0] ACK   = 8'hA5;
   localparam logic [7:0] NAK   = 8'h5A;
   localparam int         CNT_W = 20;

endpackage

// File: rtl/seq_tmo_cnt.sv
// Clearable 20-bit up-counter; term flags the last cycle an exec command may wait.
module seq_tmo_cnt
   import maze_pkg::*;
#(
   parameter int unsigned TMO_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic term
);

   localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TMO_CYCLES - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt_reg <= '0;
      else if (inc)
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign term = (cnt_reg == TERM_VAL);

endmodule

// File: rtl/maze_cmd_seq.sv
// Command sequencer: decodes UART commands, kicks one datapath resource at a
// time and returns an ACK/NAK byte once it completes or times out.
module maze_cmd_seq
   import maze_pkg::*;
#(
   parameter int unsigned TMO_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cmd,
   input  logic        cmd_rdy,
   output logic        clr_cmd_rdy,
   output logic [7:0]  resp,
   output logic        send_resp,
   input  logic        resp_sent,
   output logic        strt_cal,
   input  logic        cal_done,
   output logic [11:0] dsrd_hdg,
   output logic        strt_hdng,
   input  logic        hdg_rdy,
   output logic        strt_mv,
   output logic        stp_lft,
   output logic        stp_rght,
   input  logic        mv_cmplt,
   output logic        strt_solve,
   output logic        lft_affinity,
   input  logic        sol_cmplt,
   output logic        busy,
   output logic        err
);

   seq_state_t  state_reg;
   logic        clr_cmd_rdy_reg;
   logic [7:0]  resp_reg;
   logic        send_resp_reg;
   logic        strt_cal_reg;
   logic [11:0] dsrd_hdg_reg;
   logic        strt_hdng_reg;
   logic        strt_mv_reg;
   logic        stp_lft_reg;
   logic        stp_rght_reg;
   logic        strt_solve_reg;
   logic        lft_affinity_reg;
   logic        busy_reg;
   logic        err_reg;

   opcode_t     op;
   logic        done;
   logic        timed;
   logic        tmo_clr;
   logic        tmo_inc;
   logic        tmo_term;
   logic        cmd_unused;

   assign op         = opcode_t'(cmd[15:13]);
   assign cmd_unused = cmd[12];

   // hdg_rdy is masked during the strt_hdng cycle so a stale ready from the
   // previous heading cannot ack the new one.
   always_comb begin
      done = 1'b0;
      case (state_reg)
         CAL:     done = cal_done;
         HDG:     done = hdg_rdy && !strt_hdng_reg;
         MOVE:    done = mv_cmplt;
         SOLVE:   done = sol_cmplt;
         default: done = 1'b0;
      endcase
   end

   assign timed   = (state_reg == CAL) || (state_reg == HDG) || (state_reg == MOVE);
   assign tmo_clr = (state_reg == IDLE) && cmd_rdy;
   assign tmo_inc = timed && !done && !tmo_term;

   seq_tmo_cnt #(
      .TMO_CYCLES(TMO_CYCLES)
   ) u_tmo (
      .clk (clk),
      .rst (rst),
      .clr (tmo_clr),
      .inc (tmo_inc),
      .term(tmo_term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         clr_cmd_rdy_reg  <= 1'b0;
         resp_reg         <= 8'h00;
         send_resp_reg    <= 1'b0;
         strt_cal_reg     <= 1'b0;
         dsrd_hdg_reg     <= 12'h000;
         strt_hdng_reg    <= 1'b0;
         strt_mv_reg      <= 1'b0;
         stp_lft_reg      <= 1'b0;
         stp_rght_reg     <= 1'b0;
         strt_solve_reg   <= 1'b0;
         lft_affinity_reg <= 1'b0;
         busy_reg         <= 1'b0;
         err_reg          <= 1'b0;
      end else begin
         clr_cmd_rdy_reg <= 1'b0;
         send_resp_reg   <= 1'b0;
         strt_cal_reg    <= 1'b0;
         strt_hdng_reg   <= 1'b0;
         strt_mv_reg     <= 1'b0;
         strt_solve_reg  <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (cmd_rdy) begin
                  clr_cmd_rdy_reg <= 1'b1;
                  busy_reg        <= 1'b1;
                  err_reg         <= 1'b0;
                  case (op)
                     OP_CAL: begin
                        strt_cal_reg <= 1'b1;
                        state_reg    <= CAL;
                     end
                     OP_HDG: begin
                        dsrd_hdg_reg  <= cmd[11:0];
                        strt_hdng_reg <= 1'b1;
                        state_reg     <= HDG;
                     end
                     OP_MOVE: begin
                        stp_lft_reg  <= cmd[1];
                        stp_rght_reg <= cmd[0];
                        strt_mv_reg  <= 1'b1;
                        state_reg    <= MOVE;
                     end
                     OP_SOLVE: begin
                        lft_affinity_reg <= cmd[0];
                        strt_solve_reg   <= 1'b1;
                        state_reg        <= SOLVE;
                     end
                     default: begin
                        resp_reg      <= NAK;
                        err_reg       <= 1'b1;
                        send_resp_reg <= 1'b1;
                        state_reg     <= RESP;
                     end
                  endcase
               end
            end

            CAL, HDG, MOVE: begin
               // Completion takes priority over a timeout landing on the same cycle.
               if (done) begin
                  resp_reg      <= ACK;
                  send_resp_reg <= 1'b1;
                  state_reg     <= RESP;
               end else if (tmo_term) begin
                  resp_reg      <= NAK;
                  err_reg       <= 1'b1;
                  send_resp_reg <= 1'b1;
                  state_reg     <= RESP;
               end
            end

            SOLVE: begin
               if (done) begin
                  resp_reg      <= ACK;
                  send_resp_reg <= 1'b1;
                  state_reg     <= RESP;
               end
            end

            RESP: state_reg <= WAIT_TX;

            WAIT_TX: begin
               if (resp_sent) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_cmd_rdy  = clr_cmd_rdy_reg;
   assign resp         = resp_reg;
   assign send_resp    = send_resp_reg;
   assign strt_cal     = strt_cal_reg;
   assign dsrd_hdg     = dsrd_hdg_reg;
   assign strt_hdng    = strt_hdng_reg;
   assign strt_mv      = strt_mv_reg;
   assign stp_lft      = stp_lft_reg;
   assign stp_rght     = stp_rght_reg;
   assign strt_solve   = strt_solve_reg;
   assign lft_affinity = lft_affinity_reg;
   assign busy         = busy_reg;
   assign err          = err_reg;

endmodule

// File: tb/tb_maze_cmd_seq.sv
// Bench for maze_cmd_seq: directed scenarios plus random traffic, checked each
// cycle against a transaction-level model of the sequencer.
module tb_maze_cmd_seq;

   localparam int TMO = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cmd = 16'h0000;
   logic        cmd_rdy = 1'b0;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        send_resp;
   logic        resp_sent = 1'b0;
   logic        strt_cal;
   logic        cal_done = 1'b0;
   logic [11:0] dsrd_hdg;
   logic        strt_hdng;
   logic        hdg_rdy = 1'b0;
   logic        strt_mv;
   logic        stp_lft;
   logic        stp_rght;
   logic        mv_cmplt = 1'b0;
   logic        strt_solve;
   logic        lft_affinity;
   logic        sol_cmplt = 1'b0;
   logic        busy;
   logic        err;

   always #5 clk = ~clk;

   maze_cmd_seq #(.TMO_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
      .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent),
      .strt_cal(strt_cal), .cal_done(cal_done), .dsrd_hdg(dsrd_hdg),
      .strt_hdng(strt_hdng), .hdg_rdy(hdg_rdy), .strt_mv(strt_mv),
      .stp_lft(stp_lft), .stp_rght(stp_rght), .mv_cmplt(mv_cmplt),
      .strt_solve(strt_solve), .lft_affinity(lft_affinity), .sol_cmplt(sol_cmplt),
      .busy(busy), .err(err)
   );

   int checks = 0;
   int errors = 0;

   // Model: phase 0 idle, 1 executing, 2 response pulse, 3 awaiting tx done.
   int          m_phase, m_op, m_age;
   logic        e_clr, e_send, e_scal, e_shdg, e_smv, e_ssol;
   logic        e_sl, e_sr, e_la, e_busy, e_err;
   logic [7:0]  e_resp;
   logic [11:0] e_hdg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic done;
      e_clr = 0; e_send = 0; e_scal = 0; e_shdg = 0; e_smv = 0; e_ssol = 0;
      if (rst) begin
         m_phase = 0; e_sl = 0; e_sr = 0; e_la = 0; e_busy = 0; e_err = 0;
         e_resp = 8'h00; e_hdg = 12'h000;
      end else begin
         case (m_phase)
            0: if (cmd_rdy) begin
               e_clr = 1; e_busy = 1; m_op = int'(cmd[15:13]); m_age = 0;
               if (m_op > 3) begin
                  e_resp = 8'h5A; e_err = 1; e_send = 1; m_phase = 2;
               end else begin
                  e_err = 0; m_phase = 1;
                  case (m_op)
                     0: e_scal = 1;
                     1: begin e_shdg = 1; e_hdg = cmd[11:0]; end
                     2: begin e_smv = 1; e_sl = cmd[1]; e_sr = cmd[0]; end
                     default: begin e_ssol = 1; e_la = cmd[0]; end
                  endcase
               end
            end
            1: begin
               done = (m_op == 0 && cal_done) || (m_op == 1 && hdg_rdy && m_age > 0) ||
                      (m_op == 2 && mv_cmplt) || (m_op == 3 && sol_cmplt);
               if (done) begin
                  e_resp = 8'hA5; e_send = 1; m_phase = 2;
               end else if (m_op != 3 && m_age == TMO - 1) begin
                  e_resp = 8'h5A; e_err = 1; e_send = 1; m_phase = 2;
               end else
                  m_age++;
            end
            2: m_phase = 3;
            default: if (resp_sent) begin m_phase = 0; e_busy = 0; end
         endcase
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("clr_cmd_rdy", clr_cmd_rdy, e_clr);
      chk("send_resp", send_resp, e_send);
      chk("resp", resp, e_resp);
      chk("strt_cal", strt_cal, e_scal);
      chk("strt_hdng", strt_hdng, e_shdg);
      chk("strt_mv", strt_mv, e_smv);
      chk("strt_solve", strt_solve, e_ssol);
      chk("dsrd_hdg", dsrd_hdg, e_hdg);
      chk("stp_lft", stp_lft, e_sl);
      chk("stp_rght", stp_rght, e_sr);
      chk("lft_affinity", lft_affinity, e_la);
      chk("busy", busy, e_busy);
      chk("err", err, e_err);
      if (e_send) $display("txn op=%0d resp=%02h err=%0b t=%0t", m_op, e_resp, e_err, $time);
      if (e_clr) cmd_rdy = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic issue(input logic [15:0] c);
      int n;
      cmd = c; cmd_rdy = 1'b1; n = 0;
      while (cmd_rdy && n < 5000) begin tick(); n++; end
      chk("issue_accepted", {31'b0, cmd_rdy}, 32'd0);
   endtask

   task automatic tick_until_send(input int lim, output int n);
      n = 0;
      do begin tick(); n++; end while (!e_send && n < lim);
      chk("send_seen", send_resp, 1);
   endtask

   task automatic finish_tx();
      run(2);
      resp_sent = 1'b1; tick(); resp_sent = 1'b0;
      chk("lit_busy_idle", busy, 0);
   endtask

   initial begin
      int n;
      run(3);
      rst = 1'b0;
      chk("lit_reset_resp", resp, 8'h00);
      run(2);

      // CAL ack
      issue(16'h0000);
      chk("lit_strt_cal", strt_cal, 1);
      chk("lit_clr", clr_cmd_rdy, 1);
      run(50);
      cal_done = 1'b1; tick(); cal_done = 1'b0;
      chk("lit_cal_ack", resp, 8'hA5);
      chk("lit_cal_err", err, 0);
      finish_tx();

      // HDG with stale hdg_rdy
      hdg_rdy = 1'b1; tick();
      issue(16'h23FF);
      chk("lit_strt_hdng", strt_hdng, 1);
      chk("lit_hdg", dsrd_hdg, 12'h3FF);
      tick();
      chk("lit_no_stale_ack", send_resp, 0);
      hdg_rdy = 1'b0; run(60);
      hdg_rdy = 1'b1; tick(); hdg_rdy = 1'b0;
      chk("lit_hdg_ack", resp, 8'hA5);
      finish_tx();

      // MOVE timeout then err cleared by next command
      issue(16'h4002);
      chk("lit_stp_lft", stp_lft, 1);
      chk("lit_stp_rght", stp_rght, 0);
      tick_until_send(300, n);
      chk("lit_tmo_latency", n, TMO);
      chk("lit_tmo_nak", resp, 8'h5A);
      chk("lit_tmo_err", err, 1);
      finish_tx();
      issue(16'h0000);
      chk("lit_err_cleared", err, 0);
      cal_done = 1'b1; tick(); cal_done = 1'b0;
      finish_tx();

      // Illegal opcode
      issue(16'hE000);
      chk("lit_ill_strt", {strt_cal, strt_hdng, strt_mv, strt_solve}, 0);
      chk("lit_ill_send", send_resp, 1);
      chk("lit_ill_nak", resp, 8'h5A);
      chk("lit_ill_err", err, 1);
      finish_tx();

      // SOLVE: no timeout, queued command waits
      issue(16'h6001);
      chk("lit_lft_aff", lft_affinity, 1);
      run(2 * TMO + 50);
      chk("lit_solve_busy", busy, 1);
      cmd = 16'h0000; cmd_rdy = 1'b1;
      run(10);
      chk("lit_queued_held", cmd_rdy, 1);
      sol_cmplt = 1'b1; tick(); sol_cmplt = 1'b0;
      chk("lit_solve_ack", resp, 8'hA5);
      tick();
      resp_sent = 1'b1; tick(); resp_sent = 1'b0;
      tick();
      chk("lit_queued_strt", strt_cal, 1);
      cal_done = 1'b1; tick(); cal_done = 1'b0;
      finish_tx();

      // Reset mid-command
      issue(16'h0000);
      run(10);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("lit_rst_busy", busy, 0);
      chk("lit_rst_hdg", dsrd_hdg, 12'h000);
      chk("lit_rst_resp", resp, 8'h00);
      run(5);

      // Completion and timeout terminal on the same cycle
      issue(16'h4000);
      run(TMO - 1);
      mv_cmplt = 1'b1; tick(); mv_cmplt = 1'b0;
      chk("lit_tie_ack", resp, 8'hA5);
      chk("lit_tie_err", err, 0);
      finish_tx();

      // Random traffic
      for (int c = 0; c < 6000; c++) begin
         rst       = ($urandom_range(1499, 0) == 0);
         cal_done  = ($urandom_range(39, 0) == 0);
         hdg_rdy   = ($urandom_range(39, 0) == 0);
         mv_cmplt  = ($urandom_range(39, 0) == 0);
         sol_cmplt = ($urandom_range(39, 0) == 0);
         resp_sent = ($urandom_range(3, 0) == 0);
         if (!cmd_rdy && $urandom_range(15, 0) == 0) begin
            cmd = 16'($urandom);
            cmd_rdy = 1'b1;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
